if_prefetch_stage: RTL and testbench
====================================

# if_prefetch_stage

Parametrised instruction-fetch stage with a prefetch queue, the successor to the single-entry fetch stage. It keeps up to DEPTH fetched instructions buffered between the instruction memory port and the IF/ID pipeline register. Fetching therefore continues while the decode side is stalled, and instructions are supplied back-to-back when memory answers in one cycle. On a flush or a taken branch it redirects, discarding buffered and in-flight instructions.

## Interface
- ADDR_W, 30: word-address width (PC width)
- DATA_W, 32: instruction width
- DEPTH, 4: prefetch queue entries; power of two, 2..16
- RESET_PC, 0: fetch address after reset
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold the IF/ID outputs; no queue pop
- flush  in  1  redirect to new_pc; acts regardless of stall
- new_pc  in  ADDR_W  flush target
- br_taken  in  1  redirect to br_addr; honoured only when stall=0
- br_addr  in  ADDR_W  branch target
- mem_as_  out  1  active-low fetch request strobe
- mem_addr  out  ADDR_W  fetch word address
- mem_rd_data  in  DATA_W  instruction data, valid when mem_rdy_=0
- mem_rdy_  in  1  active-low request completion
- if_pc  out  ADDR_W  PC of if_insn
- if_insn  out  DATA_W  instruction to ID
- if_en  out  1  if_insn valid
- busy  out  1  fetch request outstanding (mem_as_=0 and mem_rdy_=1)

## Operation
- State: fetch PC fpc, queue of {pc, insn} entries with count cnt (width $clog2(DEPTH+1)), FSM {IDLE, REQ, DROP}.
- IDLE: mem_as_=1. Go to REQ when cnt + (a pop this cycle ? -1 : 0) < DEPTH and no redirect is pending.
- REQ: mem_as_=0, mem_addr=fpc. mem_as_ and mem_addr stay stable until mem_rdy_=0.
  - On mem_rdy_=0 with no redirect: push {fpc, mem_rd_data}, fpc <= fpc+1 (wraps modulo 2^ADDR_W). Stay in REQ if space remains after the push and any pop; otherwise go to IDLE.
- Redirect priority: flush > br_taken > sequential. Target is new_pc or br_addr.
  - Queue is cleared and fpc <= target.
  - If the FSM is in REQ with mem_rdy_=1, go to DROP.
  - If mem_rdy_=0 in the same cycle, the returned data is discarded and the FSM goes to REQ.
- DROP: mem_as_ stays 0 with the old address until mem_rdy_=0. Data is discarded, then go to REQ with the new fpc.
- Output register, when stall=0 and no redirect:
  - cnt>0: pop; if_pc/if_insn <= head; if_en <= 1.
  - Else: if_en <= 0, if_insn <= NOP (all zeros).
- stall=1 and no flush: outputs, queue head and cnt hold. Pushes still occur.
- Redirect: if_en <= 0, if_insn <= NOP, if_pc <= target.
- Push and pop in the same cycle are allowed; cnt is unchanged.
- cnt never exceeds DEPTH. A request is issued only if a slot is guaranteed.

## Timing
- Reset values: state IDLE, fpc=RESET_PC, cnt=0, mem_as_=1, mem_addr=RESET_PC, if_pc=RESET_PC, if_insn=0, if_en=0, busy=0.
- The first request is issued the cycle after reset is released.
- Latency, memory to output: data pushed at edge N appears on if_insn/if_en at edge N+1 at the earliest. There is no bypass.
- Redirect to first valid if_en, with single-cycle memory: 3 edges (request, push, pop).
- Throughput: one instruction per cycle when mem_rdy_ is always 0.
- Reset asserted mid-request: mem_as_ deasserts immediately (asynchronous); all state returns to reset values.

## Structure
- Shared headers: NOP encoding in isa.h. FSM state encodings and IF_DEPTH default in cpu.h.
- One sub-module: if_fifo. Synchronous FIFO parameterised by width (ADDR_W+DATA_W) and DEPTH, with push, pop, clear, cnt, and asynchronous active-low reset.

## Test plan
- Reset, then mem_rdy_ tied 0, stall=0, RESET_PC=0 -> if_en=1 from the 3rd edge; if_pc 0,1,2,… consecutive with matching data.
- stall=1 for 10 cycles, DEPTH=4 -> exactly 4 requests complete, then mem_as_=1. Outputs hold. After release, PCs continue with no gap or duplicate.
- br_taken=1, br_addr=0x100, queue holding 3 entries -> next if_en=0, if_pc=0x100, cnt=0. The next valid if_pc is 0x100.
- flush with new_pc=0x40 while a request is waiting (mem_rdy_ delayed 3 cycles) -> mem_addr holds the old address until mem_rdy_. That data is dropped; the next request uses 0x40.
- flush and br_taken together, stall=1 -> flush wins; if_pc=new_pc.
- fpc=2^30-1 -> the next fetch address is 0. Reset pulsed mid-DROP -> all outputs return to reset values.

Source files
------------

// File: rtl/if_prefetch_stage_pkg.sv
// Shared definitions for the prefetching instruction-fetch stage:
// fetch FSM encoding, NOP encoding and the default queue depth.
package if_prefetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  localparam int          IF_DEPTH = 4;
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO holding {pc, insn} entries for the prefetch queue.
// Head entry is presented combinationally; clear empties it in one edge.
module if_fifo
  import if_prefetch_stage_pkg::*;
#(
  parameter int WIDTH = 62,
  parameter int DEPTH = IF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Queue control: pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue between the
// instruction memory port and the IF/ID register. Requests are only issued
// when a queue slot is guaranteed; redirects drop queued and in-flight data.
module if_prefetch_stage
  import if_prefetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 30,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = IF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              mem_as_,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rdy_,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en,
  output logic              busy
);

  localparam int              CNT_W   = $clog2(DEPTH + 1);
  localparam int              ENT_W   = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] drop_addr;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_after_pop;
  logic [ENT_W-1:0]  head_p0;
  logic [ADDR_W-1:0] target;
  logic              redirect;
  logic              done;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] pc_p1;
  logic [DATA_W-1:0] insn_p1;
  logic              vld_p1;

  // Stage 0: fetch control -- redirect priority (flush over branch) and queue handshakes
  always_comb begin
    redirect      = flush | (br_taken & ~stall);
    target        = flush ? new_pc : br_addr;
    done          = ~mem_rdy_;
    pop           = ~stall & ~redirect & (cnt != '0);
    push          = (state == ST_REQ) & done & ~redirect;
    cnt_after_pop = cnt - {{(CNT_W-1){1'b0}}, pop};
  end

  // Stage 0: next fetch state; a request starts only if its slot is guaranteed
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!redirect && (cnt_after_pop < DEPTH_C)) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (redirect)  state_nxt = done ? ST_REQ : ST_DROP;
        else if (done) state_nxt = ((cnt_after_pop + 1'b1) < DEPTH_C) ? ST_REQ : ST_IDLE;
      end
      ST_DROP: begin
        if (done) state_nxt = ST_REQ;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage 0: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Stage 0: fetch PC; drop_addr keeps the abandoned request's address stable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc       <= RESET_PC;
      drop_addr <= RESET_PC;
    end else if (redirect) begin
      fpc <= target;
      if ((state == ST_REQ) && mem_rdy_) drop_addr <= fpc;
    end else if (push) begin
      fpc <= fpc + 1'b1;
    end
  end

  assign mem_as_  = (state == ST_IDLE);
  assign mem_addr = (state == ST_DROP) ? drop_addr : fpc;
  assign busy     = ~mem_as_ & mem_rdy_;

  if_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .wdata ({fpc, mem_rd_data}),
    .rdata (head_p0),
    .cnt   (cnt)
  );

  // Stage 1: IF/ID register fed from the queue head; no bypass from memory
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_p1   <= RESET_PC;
      insn_p1 <= DATA_W'(NOP_INSN);
      vld_p1  <= 1'b0;
    end else if (redirect) begin
      pc_p1   <= target;
      insn_p1 <= DATA_W'(NOP_INSN);
      vld_p1  <= 1'b0;
    end else if (!stall) begin
      if (cnt != '0) begin
        pc_p1   <= head_p0[ENT_W-1:DATA_W];
        insn_p1 <= head_p0[DATA_W-1:0];
        vld_p1  <= 1'b1;
      end else begin
        insn_p1 <= DATA_W'(NOP_INSN);
        vld_p1  <= 1'b0;
      end
    end
  end

  assign if_pc   = pc_p1;
  assign if_insn = insn_p1;
  assign if_en   = vld_p1;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: streaming fetch, stall fill,
// branch and flush redirects, drop of an in-flight request, PC wrap and
// asynchronous reset during a dropped request.
module tb_if_prefetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [29:0] new_pc;
  logic        br_taken;
  logic [29:0] br_addr;
  logic        mem_as_;
  logic [29:0] mem_addr;
  logic [31:0] mem_rd_data;
  logic        mem_rdy_;
  logic [29:0] if_pc;
  logic [31:0] if_insn;
  logic        if_en;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int n_done;
  int n_wait;

  always #5 clk = ~clk;

  if_prefetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .br_taken    (br_taken),
    .br_addr     (br_addr),
    .mem_as_     (mem_as_),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_rdy_    (mem_rdy_),
    .if_pc       (if_pc),
    .if_insn     (if_insn),
    .if_en       (if_en),
    .busy        (busy)
  );

  // Instruction memory image: every word carries its own address
  function automatic logic [31:0] insn_of(input logic [29:0] a);
    return {2'b10, a} ^ 32'h0F0F_0000;
  endfunction

  assign mem_rd_data = insn_of(mem_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_as"},   mem_as_,  1);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_pc"},   if_pc,    0);
    check({tag, "_insn"}, if_insn,  0);
    check({tag, "_en"},   if_en,    0);
    check({tag, "_busy"}, busy,     0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    new_pc = '0; br_addr = '0; mem_rdy_ = 1'b1;
    tick(); tick();
    check_reset_state("rst");

    // Streaming with single-cycle memory
    mem_rdy_ = 1'b0;
    reset    = 1'b1;
    tick();
    check("first_req_as", mem_as_, 0);
    check("first_req_addr", mem_addr, 0);
    check("edge1_en", if_en, 0);
    tick();
    check("edge2_en", if_en, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("stream_en", if_en, 1);
      check("stream_pc", if_pc, k);
      check("stream_insn", if_insn, insn_of(30'(k)));
    end
    check("stream_busy", busy, 0);

    // Hold off memory one cycle so the queue drains, then stall
    mem_rdy_ = 1'b1;
    #1;
    check("wait_busy", busy, 1);
    tick();
    check("drain_pc", if_pc, 6);
    stall    = 1'b1;
    mem_rdy_ = 1'b0;
    n_done   = 0;
    for (int k = 0; k < 10; k++) begin
      if (!mem_as_ && !mem_rdy_) n_done++;
      tick();
      check("stall_hold_pc", if_pc, 6);
    end
    check("stall_fills", n_done, 4);
    check("stall_as_idle", mem_as_, 1);
    check("stall_hold_en", if_en, 1);
    check("stall_hold_insn", if_insn, insn_of(30'd6));
    stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("resume_en", if_en, 1);
      check("resume_pc", if_pc, 7 + k);
      check("resume_insn", if_insn, insn_of(30'(7 + k)));
    end
    check("queue_before_br", dut.cnt, 3);

    // Taken branch with three queued entries
    br_taken = 1'b1;
    br_addr  = 30'h100;
    tick();
    br_taken = 1'b0;
    check("br_en", if_en, 0);
    check("br_pc", if_pc, 30'h100);
    check("br_insn", if_insn, 0);
    check("br_cnt", dut.cnt, 0);
    check("br_addr", mem_addr, 30'h100);
    n_wait = 0;
    while (!if_en && n_wait < 8) begin tick(); n_wait++; end
    check("br_valid_seen", if_en, 1);
    check("br_first_pc", if_pc, 30'h100);
    check("br_first_insn", if_insn, insn_of(30'h100));
    tick();
    check("br_next_pc", if_pc, 30'h101);

    // Flush while a request is waiting on memory
    mem_rdy_ = 1'b1;
    flush    = 1'b1;
    new_pc   = 30'h40;
    tick();
    flush = 1'b0;
    check("drop_as", mem_as_, 0);
    check("drop_addr", mem_addr, 30'h103);
    check("drop_busy", busy, 1);
    check("flush_pc", if_pc, 30'h40);
    check("flush_en", if_en, 0);
    tick();
    check("drop_hold_addr1", mem_addr, 30'h103);
    check("drop_hold_as1", mem_as_, 0);
    tick();
    check("drop_hold_addr2", mem_addr, 30'h103);
    mem_rdy_ = 1'b0;
    tick();
    check("after_drop_addr", mem_addr, 30'h40);
    check("after_drop_as", mem_as_, 0);
    check("after_drop_en", if_en, 0);
    n_wait = 0;
    while (!if_en && n_wait < 8) begin tick(); n_wait++; end
    check("flush_valid_seen", if_en, 1);
    check("flush_first_pc", if_pc, 30'h40);
    check("flush_first_insn", if_insn, insn_of(30'h40));

    // Flush and branch together under stall: flush wins
    stall    = 1'b1;
    flush    = 1'b1;
    new_pc   = 30'h200;
    br_taken = 1'b1;
    br_addr  = 30'h300;
    tick();
    flush = 1'b0;
    check("prio_pc", if_pc, 30'h200);
    check("prio_en", if_en, 0);
    check("prio_addr", mem_addr, 30'h200);
    tick();
    check("stalled_br_ignored_pc", if_pc, 30'h200);
    check("stalled_br_ignored_en", if_en, 0);
    check("stalled_fetch_addr", mem_addr, 30'h201);
    br_taken = 1'b0;
    stall    = 1'b0;
    tick();
    check("prio_valid_en", if_en, 1);
    check("prio_valid_pc", if_pc, 30'h200);

    // Fetch address wraps past the top of the address space
    flush  = 1'b1;
    new_pc = 30'h3FFF_FFFF;
    tick();
    flush = 1'b0;
    check("wrap_top_addr", mem_addr, 30'h3FFF_FFFF);
    tick();
    check("wrap_next_addr", mem_addr, 0);
    tick();
    check("wrap_top_pc", if_pc, 30'h3FFF_FFFF);
    check("wrap_top_en", if_en, 1);
    tick();
    check("wrap_zero_pc", if_pc, 0);
    check("wrap_zero_insn", if_insn, insn_of(30'd0));

    // Asynchronous reset in the middle of a dropped request
    mem_rdy_ = 1'b1;
    flush    = 1'b1;
    new_pc   = 30'h80;
    tick();
    flush = 1'b0;
    check("pre_rst_drop_as", mem_as_, 0);
    check("pre_rst_drop_addr", mem_addr, 30'h2);
    check("pre_rst_pc", if_pc, 30'h80);
    #3;
    reset = 1'b0;
    #1;
    check_reset_state("async_rst");
    tick();
    reset    = 1'b1;
    mem_rdy_ = 1'b0;
    tick();
    check("rerun_as", mem_as_, 0);
    check("rerun_addr", mem_addr, 0);
    tick();
    tick();
    check("rerun_en", if_en, 1);
    check("rerun_pc", if_pc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
